// File: rtl/fwd_ctrl.sv
// Decode-stage forwarding/hazard controller: six-slot scoreboard of in-flight writes (E..M5).
// Latency: fwd and hazard_stall are combinational from dec inputs and slot state; slots move on the clock edge.
// Backpressure: stall_ext freezes every slot and stall_cnt; hazard_stall holds decode and bubbles slot 1.
module fwd_ctrl #(
    parameter int NSRC  = 6,
    parameter int NSLOT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [6*NSRC-1:0]    dec_src,
    input  logic [NSRC-1:0]      dec_use,
    input  logic                 dec_regwrite,
    input  logic [5:0]           dec_rd,
    input  logic [2:0]           dec_lat,
    input  logic                 stall_ext,
    input  logic                 flush,
    output logic [3*NSRC-1:0]    fwd,
    output logic                 hazard_stall,
    output logic [31:0]          stall_cnt
);

    // Slot index 0 is E (stage number 1), index NSLOT-1 is the oldest stage.
    logic [NSLOT-1:0]      vld_q, vld_d;
    logic [NSLOT-1:0][5:0] rd_q, rd_d;
    logic [NSLOT-1:0][2:0] lat_q, lat_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [NSRC-1:0]       not_rdy;
    logic [5:0]            src;
    logic [2:0]            lat_c;

    // Lookup: scan from oldest to youngest so the youngest match (lowest slot) wins,
    // even when that youngest copy is not ready yet.
    always_comb begin
        fwd     = '0;
        not_rdy = '0;
        src     = '0;
        for (int i = 0; i < NSRC; i++) begin
            src = dec_src[6*i +: 6];
            for (int k = NSLOT - 1; k >= 0; k--) begin
                if (vld_q[k] && (rd_q[k] == src) && (src != 6'd0)) begin
                    if (lat_q[k] <= 3'(k + 1)) begin
                        fwd[3*i +: 3] = 3'(k + 1);
                        not_rdy[i]    = 1'b0;
                    end else begin
                        fwd[3*i +: 3] = 3'd0;
                        not_rdy[i]    = 1'b1;
                    end
                end
            end
        end
    end

    // A squashed instruction never stalls; only sources actually read can stall.
    assign hazard_stall = dec_valid & ~flush & (|(dec_use & not_rdy));
    assign stall_cnt    = cnt_q;

    // Latency 0 behaves as E and 7 as M5 so every entry eventually becomes ready.
    assign lat_c = (dec_lat == 3'd0) ? 3'd1 :
                   (dec_lat == 3'd7) ? 3'd6 : dec_lat;

    // Next state: shift the pipeline unless frozen; slot 1 takes the decoded write or a bubble.
    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        lat_d = lat_q;
        cnt_d = cnt_q;
        if (!stall_ext) begin
            for (int k = NSLOT - 1; k >= 1; k--) begin
                vld_d[k] = vld_q[k-1];
                rd_d[k]  = rd_q[k-1];
                lat_d[k] = lat_q[k-1];
            end
            vld_d[0] = dec_valid & ~flush & ~hazard_stall & dec_regwrite & (dec_rd != 6'd0);
            rd_d[0]  = dec_rd;
            lat_d[0] = lat_c;
            if (hazard_stall) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // State register; reset discards all in-flight entries and overrides stall_ext/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            lat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: forwarding selects, load-use stalls, shadowing, freeze, flush, reset.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later, well before the next edge.
// Each scenario task carries its own inline comparisons against hand-computed values.
module tb_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [35:0] dec_src;
    logic [5:0]  dec_use;
    logic        dec_regwrite;
    logic [5:0]  dec_rd;
    logic [2:0]  dec_lat;
    logic        stall_ext;
    logic        flush;
    logic [17:0] fwd;
    logic        hazard_stall;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl #(.NSRC(6), .NSLOT(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_src      (dec_src),
        .dec_use      (dec_use),
        .dec_regwrite (dec_regwrite),
        .dec_rd       (dec_rd),
        .dec_lat      (dec_lat),
        .stall_ext    (stall_ext),
        .flush        (flush),
        .fwd          (fwd),
        .hazard_stall (hazard_stall),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_valid    = 1'b0;
        dec_src      = '0;
        dec_use      = '0;
        dec_regwrite = 1'b0;
        dec_rd       = '0;
        dec_lat      = '0;
        stall_ext    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [5:0] r);
        dec_src[6*i +: 6] = r;
    endtask

    task automatic do_reset();
        clear_dec();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Non-reading writer instruction, advanced through one edge.
    task automatic issue(input logic [5:0] rd, input logic [2:0] lat);
        clear_dec();
        dec_valid    = 1'b1;
        dec_regwrite = 1'b1;
        dec_rd       = rd;
        dec_lat      = lat;
        tick();
        clear_dec();
    endtask

    // Non-writing reader of src0 (and optionally src1).
    task automatic reader(input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] use_v);
        clear_dec();
        dec_valid = 1'b1;
        set_src(0, s0);
        set_src(1, s1);
        dec_use = use_v;
    endtask

    task automatic test_reset();
        do_reset();
        reader(6'd5, 6'd0, 6'b000001);
        #1;
        if (fwd[2:0] !== 3'd0) begin $display("FAIL reset_fwd0: got %0d want 0", fwd[2:0]); n_fail++; end
        n_checks++;
        if (hazard_stall !== 1'b0) begin $display("FAIL reset_stall: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        if (stall_cnt !== 32'd0) begin $display("FAIL reset_cnt: got %0d want 0", stall_cnt); n_fail++; end
        n_checks++;
    endtask

    task automatic test_alu();
        do_reset();
        issue(6'd5, 3'd1);
        reader(6'd5, 6'd5, 6'b000011);
        #1;
        if (fwd[2:0] !== 3'd1) begin $display("FAIL alu_fwd0: got %0d want 1", fwd[2:0]); n_fail++; end
        n_checks++;
        if (fwd[5:3] !== 3'd1) begin $display("FAIL alu_fwd1: got %0d want 1", fwd[5:3]); n_fail++; end
        n_checks++;
        if (hazard_stall !== 1'b0) begin $display("FAIL alu_stall: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        tick();
        clear_dec();
        for (int n = 0; n < 4; n++) tick();
        reader(6'd5, 6'd0, 6'b000001);
        #1;
        if (fwd[2:0] !== 3'd6) begin $display("FAIL alu_m5: got %0d want 6", fwd[2:0]); n_fail++; end
        n_checks++;
        tick();
        if (fwd[2:0] !== 3'd0) begin $display("FAIL alu_retired: got %0d want 0", fwd[2:0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        issue(6'd7, 3'd2);
        reader(6'd7, 6'd0, 6'b000001);
        dec_regwrite = 1'b1;
        dec_rd       = 6'd9;
        dec_lat      = 3'd1;
        #1;
        if (hazard_stall !== 1'b1) begin $display("FAIL load_stall: got %0b want 1", hazard_stall); n_fail++; end
        n_checks++;
        tick();
        if (hazard_stall !== 1'b0) begin $display("FAIL load_release: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        if (fwd[2:0] !== 3'd2) begin $display("FAIL load_fwd: got %0d want 2", fwd[2:0]); n_fail++; end
        n_checks++;
        if (stall_cnt !== 32'd1) begin $display("FAIL load_cnt: got %0d want 1", stall_cnt); n_fail++; end
        n_checks++;
        tick();
        reader(6'd9, 6'd7, 6'b000011);
        #1;
        if (fwd[2:0] !== 3'd1) begin $display("FAIL load_bubble_rd9: got %0d want 1", fwd[2:0]); n_fail++; end
        n_checks++;
        if (fwd[5:3] !== 3'd3) begin $display("FAIL load_rd7_m2: got %0d want 3", fwd[5:3]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_shadow();
        do_reset();
        issue(6'd3, 3'd1);
        issue(6'd20, 3'd1);
        issue(6'd3, 3'd1);
        reader(6'd3, 6'd0, 6'b000001);
        #1;
        if (fwd[2:0] !== 3'd1) begin $display("FAIL shadow_youngest: got %0d want 1", fwd[2:0]); n_fail++; end
        n_checks++;
        tick();
        issue(6'd3, 3'd5);
        reader(6'd3, 6'd0, 6'b000000);
        #1;
        if (hazard_stall !== 1'b0) begin $display("FAIL unused_src_stall: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        dec_use = 6'b000001;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (hazard_stall !== 1'b1) begin $display("FAIL fpu_stall_%0d: got %0b want 1", n, hazard_stall); n_fail++; end
            n_checks++;
            tick();
        end
        if (hazard_stall !== 1'b0) begin $display("FAIL fpu_release: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        if (fwd[2:0] !== 3'd5) begin $display("FAIL fpu_fwd: got %0d want 5", fwd[2:0]); n_fail++; end
        n_checks++;
        if (stall_cnt !== 32'd4) begin $display("FAIL fpu_cnt: got %0d want 4", stall_cnt); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reg_zero_f0();
        do_reset();
        issue(6'd0, 3'd1);
        reader(6'd0, 6'd0, 6'b000001);
        #1;
        if (fwd[2:0] !== 3'd0) begin $display("FAIL r0_fwd: got %0d want 0", fwd[2:0]); n_fail++; end
        n_checks++;
        issue(6'd32, 3'd1);
        reader(6'd32, 6'd0, 6'b000001);
        #1;
        if (fwd[2:0] !== 3'd1) begin $display("FAIL f0_fwd: got %0d want 1", fwd[2:0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_stall_ext();
        do_reset();
        issue(6'd14, 3'd1);
        issue(6'd12, 3'd5);
        reader(6'd12, 6'd14, 6'b000011);
        stall_ext = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            if (hazard_stall !== 1'b1) begin $display("FAIL ext_stall_%0d: got %0b want 1", n, hazard_stall); n_fail++; end
            n_checks++;
            if (fwd[5:3] !== 3'd2) begin $display("FAIL ext_fwd1_%0d: got %0d want 2", n, fwd[5:3]); n_fail++; end
            n_checks++;
            if (stall_cnt !== 32'd0) begin $display("FAIL ext_cnt_%0d: got %0d want 0", n, stall_cnt); n_fail++; end
            n_checks++;
            tick();
        end
        stall_ext = 1'b0;
        tick();
        if (stall_cnt !== 32'd1) begin $display("FAIL ext_resume_cnt: got %0d want 1", stall_cnt); n_fail++; end
        n_checks++;
        if (fwd[5:3] !== 3'd3) begin $display("FAIL ext_resume_fwd1: got %0d want 3", fwd[5:3]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_flush();
        do_reset();
        issue(6'd12, 3'd5);
        reader(6'd12, 6'd0, 6'b000001);
        dec_regwrite = 1'b1;
        dec_rd       = 6'd9;
        dec_lat      = 3'd1;
        flush        = 1'b1;
        #1;
        if (hazard_stall !== 1'b0) begin $display("FAIL flush_stall: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        tick();
        clear_dec();
        set_src(0, 6'd9);
        set_src(1, 6'd12);
        #1;
        if (fwd[2:0] !== 3'd0) begin $display("FAIL flush_no_insert: got %0d want 0", fwd[2:0]); n_fail++; end
        n_checks++;
        if (stall_cnt !== 32'd0) begin $display("FAIL flush_cnt: got %0d want 0", stall_cnt); n_fail++; end
        n_checks++;
        dec_valid = 1'b1;
        dec_use   = 6'b000010;
        #1;
        if (hazard_stall !== 1'b1) begin $display("FAIL flush_shifted: got %0b want 1", hazard_stall); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(6'd5, 3'd1);
        issue(6'd6, 3'd5);
        reader(6'd5, 6'd6, 6'b000011);
        #1;
        if (hazard_stall !== 1'b1) begin $display("FAIL mid_pre_stall: got %0b want 1", hazard_stall); n_fail++; end
        n_checks++;
        tick();
        rst       = 1'b1;
        stall_ext = 1'b1;
        tick();
        if (fwd !== 18'd0) begin $display("FAIL mid_fwd: got %0h want 0", fwd); n_fail++; end
        n_checks++;
        if (hazard_stall !== 1'b0) begin $display("FAIL mid_stall: got %0b want 0", hazard_stall); n_fail++; end
        n_checks++;
        if (stall_cnt !== 32'd0) begin $display("FAIL mid_cnt: got %0d want 0", stall_cnt); n_fail++; end
        n_checks++;
        rst = 1'b0;
        clear_dec();
    endtask

    initial begin
        rst = 1'b1;
        clear_dec();
        test_reset();
        test_alu();
        test_load_use();
        test_shadow();
        test_reg_zero_f0();
        test_stall_ext();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and hazard controller for the decode stage. It keeps a six-slot scoreboard of in-flight register writes, one slot per stage from E through M5. Each cycle it produces the six 3-bit forward selects that drive the decode operand muxes, and it raises a load-use/latency stall when a needed value is not yet produced. It sits beside decode, sees each decoded instruction's sources and destination, and advances with the pipeline.

## Interface
- NSRC, default 6: number of source operands (rs0, rs1, reg2..reg5).
- NSLOT, default 6: scoreboard depth (E, M, M2, M3, M4, M5).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- dec_valid  in  1  decode holds a real instruction this cycle.
- dec_src  in  6*NSRC  source register ids; entry i is bits [6i+5:6i], register space 0..63.
- dec_use  in  NSRC  entry i set = source i is actually read.
- dec_regwrite  in  1  instruction writes dec_rd (scalar or vector).
- dec_rd  in  6  destination register id.
- dec_lat  in  3  stage index where the result first exists: 1=E, 2=M, …, 6=M5.
- stall_ext  in  1  downstream freeze; whole pipeline holds.
- flush  in  1  decode instruction is squashed (mispredict).
- fwd  out  3*NSRC  forward select per source: 000 regfile, 001 E, 010 M, 011 M2, 100 M3, 101 M4, 110 M5.
- hazard_stall  out  1  hold fetch/decode and insert bubble into E.
- stall_cnt  out  32  count of cycles with hazard_stall=1.

## Operation
- Each slot k (1..6) holds: valid, rd[5:0], lat[2:0]. Slot 1 is E, slot 6 is M5.
- Register 0 is hardwired zero and is never tracked. Register 32 (f0) is ordinary.
- Lookup is combinational from registered slots, for each source i:
  - Find the lowest k with slot valid and rd == src_i and src_i != 0.
  - No match: fwd_i = 000.
  - Match with lat <= k: fwd_i = k.
  - Match with lat > k: the source is not ready.
  - Younger matches in lower slots shadow older ones, even if the younger one is not ready.
- hazard_stall = dec_valid & ~flush & OR over i of (dec_use[i] & not-ready_i).
- dec_lat is clamped: 0 counts as 1, 7 counts as 6.
- Advance, when stall_ext=0:
  - Slots shift k→k+1. Slot 6 drops; the regfile is written that edge.
  - Slot 1 loads {dec_valid & ~flush & ~hazard_stall & dec_regwrite & (dec_rd != 0), dec_rd, clamped lat}.
  - When hazard_stall=1, slot 1 becomes invalid (bubble).
- When stall_ext=1, all slots hold. Outputs keep being recomputed from the held state and current dec inputs.
- stall_cnt increments by 1 on every edge where hazard_stall=1 and stall_ext=0. It wraps at 2^32.

## Timing
- fwd and hazard_stall are combinational from dec inputs and slot state, valid in the same cycle decode presents operands. There is no output register.
- An instruction with lat=L issued at edge t is forwardable to a reader decoding in the cycle after edge t+L-1. Examples:
  - ALU (L=1): reader in the next cycle gets 001, with no stall.
  - Load (L=2): a back-to-back reader sees 1 stall cycle, then gets 010.
- An FPU op with L=5 that is read back-to-back stalls 4 cycles, then gets 101.
- Reset: all slots invalid; stall_cnt = 0; therefore fwd = all 000 and hazard_stall = 0 in the cycle after reset asserts.
- Reset mid-operation discards every in-flight entry at that edge. Reset wins over stall_ext and flush.
- flush together with hazard_stall: flush wins, hazard_stall = 0, and slot 1 gets a bubble.
- stall_ext together with hazard_stall: no shift, no insertion, stall_cnt unchanged.

## Test plan
- Reset, then dec_src0=5, use0=1 -> fwd0=000, hazard_stall=0, stall_cnt=0.
- Issue rd=5, lat=1, then the next cycle src0=5, src1=5 -> fwd0=fwd1=001, no stall. After 5 more advances a reader gets 110; after 6, 000.
- Load rd=7, lat=2, then an immediate reader of 7 -> hazard_stall=1 for 1 cycle with a bubble in E. Next cycle fwd=010, stall_cnt=1.
- rd=3 issued with lat=1, one unrelated instruction, rd=3 issued again with lat=1 -> a reader gets 001 (youngest), not 011. A younger rd=3 with lat=5 in E forces a stall even though an older ready copy exists.
- rd=0 write followed by a reader of 0 -> 000. rd=32 write followed by a reader of 32 -> 001. A use=0 source matching an unready entry -> no stall.
- stall_ext held 3 cycles with a lat=5 entry in E -> fwd/stall unchanged, stall_cnt frozen. flush during a pending stall -> no insertion, hazard_stall=0. rst mid-stream -> all fwd=000 next cycle.
